// File: rtl/seg_7_reader.sv
// Receive side of a multiplexed 7-segment bus: debounces {com,seg}, decodes each
// glyph back to a nibble and publishes a 4-digit frame once all positions are seen.
module seg_7_reader #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  seg,
   input  logic [3:0]  com,
   input  logic        err_clr,
   output logic [15:0] digits,
   output logic        frame_valid,
   output logic        err,
   output logic [1:0]  err_cause
);

   localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

   logic [10:0] samp;
   logic [7:0]  run;
   logic [7:0]  run_nxt;
   logic        accept;
   logic [3:0]  mask;
   logic [3:0]  mask_nxt;
   logic [15:0] shadow;
   logic [15:0] shadow_nxt;
   logic [3:0]  com_s;
   logic [6:0]  seg_s;
   logic [3:0]  glyph_val;
   logic        glyph_ok;
   logic        com_one;
   logic        com_multi;
   logic        slot_wr;
   logic        frame_done;
   logic [1:0]  new_cause;

   assign com_s = samp[10:7];
   assign seg_s = samp[6:0];

   // Saturating run length of identical samples; a change restarts the run at 1.
   always_comb begin
      run_nxt = 8'd1;
      if ({com, seg} == samp) begin
         run_nxt = (run == 8'hFF) ? run : run + 8'd1;
      end
   end

   always_comb begin
      glyph_ok  = 1'b1;
      glyph_val = 4'h0;
      case (seg_s)
         7'h7E: glyph_val = 4'h0;
         7'h30: glyph_val = 4'h1;
         7'h6D: glyph_val = 4'h2;
         7'h79: glyph_val = 4'h3;
         7'h33: glyph_val = 4'h4;
         7'h5B: glyph_val = 4'h5;
         7'h5F: glyph_val = 4'h6;
         7'h70: glyph_val = 4'h7;
         7'h7F: glyph_val = 4'h8;
         7'h7B: glyph_val = 4'h9;
         7'h77: glyph_val = 4'hA;
         7'h1F: glyph_val = 4'hB;
         7'h4E: glyph_val = 4'hC;
         7'h3D: glyph_val = 4'hD;
         7'h4F: glyph_val = 4'hE;
         7'h47: glyph_val = 4'hF;
         default: glyph_ok = 1'b0;
      endcase
   end

   assign com_multi = (com_s & (com_s - 4'd1)) != 4'd0;
   assign com_one   = (com_s != 4'd0) && !com_multi;

   always_comb begin
      new_cause  = 2'b00;
      slot_wr    = 1'b0;
      shadow_nxt = shadow;
      mask_nxt   = mask;
      if (accept) begin
         if (com_multi) begin
            new_cause[1] = 1'b1;
         end else if (com_one) begin
            if (glyph_ok) slot_wr = 1'b1;
            else new_cause[0] = 1'b1;
         end
      end
      if (slot_wr) begin
         for (int i = 0; i < 4; i++) begin
            if (com_s[i]) shadow_nxt[4*i +: 4] = glyph_val;
         end
         mask_nxt = mask | com_s;
      end
   end

   assign frame_done = slot_wr && (mask_nxt == 4'hF);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         samp        <= '0;
         run         <= '0;
         accept      <= 1'b0;
         mask        <= '0;
         shadow      <= '0;
         digits      <= '0;
         frame_valid <= 1'b0;
         err         <= 1'b0;
         err_cause   <= '0;
      end else begin
         samp        <= {com, seg};
         run         <= run_nxt;
         // Pulse only on the transition so a held pattern is taken once per run.
         accept      <= (run_nxt == STABLE) && (run != STABLE);
         shadow      <= shadow_nxt;
         mask        <= frame_done ? 4'b0000 : mask_nxt;
         frame_valid <= frame_done;
         if (frame_done) digits <= shadow_nxt;
         if (err_clr) begin
            err       <= |new_cause;
            err_cause <= new_cause;
         end else begin
            err       <= err | (|new_cause);
            err_cause <= err_cause | new_cause;
         end
      end
   end

endmodule

// File: tb/tb_seg_7_reader.sv
// Bench for seg_7_reader: drives digit scans, glitches, illegal patterns and resets;
// expected frames are queued at stimulus time and matched on frame_valid.
module tb_seg_7_reader;

   logic        clk;
   logic        rst;
   logic [6:0]  seg;
   logic [3:0]  com;
   logic        err_clr;
   logic [15:0] digits;
   logic        frame_valid;
   logic        err;
   logic [1:0]  err_cause;

   int total = 0;
   int bad = 0;
   int fv_cnt = 0;
   int fv_base;
   int lat;
   logic [15:0] exp_q[$];

   seg_7_reader #(.STABLE_CYCLES(4)) dut (
      .clk(clk),
      .rst(rst),
      .seg(seg),
      .com(com),
      .err_clr(err_clr),
      .digits(digits),
      .frame_valid(frame_valid),
      .err(err),
      .err_cause(err_cause)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [6:0] enc(input logic [3:0] v);
      case (v)
         4'h0: enc = 7'h7E;  4'h1: enc = 7'h30;  4'h2: enc = 7'h6D;  4'h3: enc = 7'h79;
         4'h4: enc = 7'h33;  4'h5: enc = 7'h5B;  4'h6: enc = 7'h5F;  4'h7: enc = 7'h70;
         4'h8: enc = 7'h7F;  4'h9: enc = 7'h7B;  4'hA: enc = 7'h77;  4'hB: enc = 7'h1F;
         4'hC: enc = 7'h4E;  4'hD: enc = 7'h3D;  4'hE: enc = 7'h4F;  default: enc = 7'h47;
      endcase
   endfunction

   // Drive a pattern and hold it for n clock edges.
   task automatic put(input logic [3:0] c, input logic [6:0] s, input int n);
      com = c;
      seg = s;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send3(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2);
      put(4'b0001, enc(d0), 6);
      put(4'b0010, enc(d1), 6);
      put(4'b0100, enc(d2), 6);
   endtask

   // Scoreboard: every published frame must match the oldest queued expectation.
   always @(negedge clk) begin
      if (frame_valid) begin
         fv_cnt++;
         if (exp_q.size() == 0) check_eq("unexpected_frame", digits, 16'hxxxx);
         else check_eq("frame", digits, exp_q.pop_front());
      end
   end

   initial begin
      rst = 1'b1;
      com = 4'b0000;
      seg = 7'h00;
      err_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_digits", digits, 16'h0000);
      check_eq("rst_fv", {15'd0, frame_valid}, 16'd0);
      check_eq("rst_err", {15'd0, err}, 16'd0);
      check_eq("rst_cause", {14'd0, err_cause}, 16'd0);
      rst = 1'b0;
      put(4'b0000, 7'h00, 4);

      // Basic scan 3,5,C,1
      exp_q.push_back(16'h1C53);
      put(4'b0001, 7'h79, 6);
      put(4'b0010, 7'h5B, 6);
      put(4'b0100, 7'h4E, 6);
      put(4'b1000, 7'h30, 6);
      put(4'b0000, 7'h00, 2);
      check_eq("scan_frames", 16'(fv_cnt), 16'd1);
      check_eq("scan_digits", digits, 16'h1C53);
      check_eq("scan_err", {15'd0, err}, 16'd0);

      // Latency: last slot written at edge 4 counting the first edge as 0
      send3(4'h1, 4'h2, 4'h3);
      exp_q.push_back(16'h4321);
      com = 4'b1000;
      seg = enc(4'h4);
      lat = -1;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         if (frame_valid && lat < 0) lat = k;
      end
      check_eq("latency", 16'(lat), 16'd4);
      put(4'b0000, 7'h00, 4);

      // Short glitch is not accepted; earlier slots survive
      fv_base = fv_cnt;
      send3(4'h7, 4'h8, 4'h9);
      put(4'b1000, enc(4'h6), 3);
      put(4'b0000, 7'h00, 6);
      check_eq("glitch_no_frame", 16'(fv_cnt - fv_base), 16'd0);
      exp_q.push_back(16'h6987);
      put(4'b1000, enc(4'h6), 40);
      check_eq("long_hold_frame", 16'(fv_cnt - fv_base), 16'd1);
      // A second accept of digit 3 during the long hold would complete this early
      send3(4'hA, 4'hB, 4'hC);
      put(4'b0000, 7'h00, 6);
      check_eq("single_accept", 16'(fv_cnt - fv_base), 16'd1);
      exp_q.push_back(16'hDCBA);
      put(4'b1000, enc(4'hD), 6);
      put(4'b0000, 7'h00, 4);
      check_eq("resume_frame", 16'(fv_cnt - fv_base), 16'd2);

      // Illegal glyph
      fv_base = fv_cnt;
      put(4'b0100, 7'h00, 8);
      check_eq("glyph_err", {15'd0, err}, 16'd1);
      check_eq("glyph_cause", {14'd0, err_cause}, 16'd1);
      check_eq("glyph_no_frame", 16'(fv_cnt - fv_base), 16'd0);
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      check_eq("clr_err", {15'd0, err}, 16'd0);
      check_eq("clr_cause", {14'd0, err_cause}, 16'd0);

      // Illegal com
      put(4'b0011, enc(4'h1), 8);
      check_eq("com_err", {15'd0, err}, 16'd1);
      check_eq("com_cause", {14'd0, err_cause}, 16'd2);

      // err_clr coinciding with a new error: only the new cause remains
      put(4'b0100, 7'h00, 8);
      check_eq("both_cause", {14'd0, err_cause}, 16'd3);
      com = 4'b0011;
      seg = enc(4'h2);
      repeat (4) @(posedge clk);
      #1;
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      check_eq("clr_race_err", {15'd0, err}, 16'd1);
      check_eq("clr_race_cause", {14'd0, err_cause}, 16'd2);
      err_clr = 1'b1;
      put(4'b0000, 7'h00, 1);
      err_clr = 1'b0;
      put(4'b0000, 7'h00, 4);
      check_eq("clr2_cause", {14'd0, err_cause}, 16'd0);

      // Blanking between digits, digit 2 overwritten 8 -> A
      exp_q.push_back(16'hFA65);
      put(4'b0100, enc(4'h8), 6);
      put(4'b0000, 7'h00, 6);
      put(4'b0100, enc(4'hA), 6);
      put(4'b0000, 7'h00, 6);
      put(4'b0001, enc(4'h5), 6);
      put(4'b0000, 7'h00, 6);
      put(4'b0010, enc(4'h6), 6);
      put(4'b0000, 7'h00, 6);
      put(4'b1000, enc(4'hF), 6);
      put(4'b0000, 7'h00, 4);
      check_eq("blank_digits", digits, 16'hFA65);
      check_eq("blank_err", {15'd0, err}, 16'd0);

      // Reset mid-frame discards partial capture
      fv_base = fv_cnt;
      send3(4'h1, 4'h2, 4'h3);
      rst = 1'b1;
      #1;
      check_eq("async_rst_digits", digits, 16'h0000);
      @(posedge clk);
      #1;
      rst = 1'b0;
      put(4'b1000, enc(4'h4), 8);
      put(4'b0000, 7'h00, 4);
      check_eq("rst_no_frame", 16'(fv_cnt - fv_base), 16'd0);
      check_eq("rst_digits_after", digits, 16'h0000);

      check_eq("queue_empty", 16'(exp_q.size()), 16'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seg_7_reader.md
Name: seg_7_reader

Overview:
- Receive side of the multiplexed 7-segment bus. Monitors the segment lines and digit-select (com) lines produced by the board's display drivers and recovers the four hex digits being shown.
- Used as a loopback checker in lab benches and to mirror the display contents into downstream logic.
- Samples the bus, waits for each pattern to be stable, decodes the glyph back to a 4-bit value, and publishes a complete 4-digit frame once every digit position has been seen.

Parameters:
STABLE_CYCLES, 4, number of consecutive identical {com,seg} samples before a pattern is accepted (legal range 2..255)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
seg  input  7  segment lines, active-high; seg[6]=a, seg[5]=b, seg[4]=c, seg[3]=d, seg[2]=e, seg[1]=f, seg[0]=g
com  input  4  digit select, active-high one-hot; com[i]=1 selects digit i (4'b0001 = digit 0)
err_clr  input  1  synchronous clear of err and err_cause
digits  output  16  last complete frame; digit i in digits[4i+3:4i]
frame_valid  output  1  one-cycle pulse when digits is updated
err  output  1  sticky error flag
err_cause  output  2  sticky; bit0 = illegal glyph, bit1 = illegal com (more than one bit set)

Behaviour:
- Reset (async, rst=1) clears all state immediately: digits=16'h0000, frame_valid=0, err=0, err_cause=2'b00, sample register=0, run counter=0, slot-captured mask=4'b0000, shadow slots=0. Reset mid-frame discards any partial capture.
- Input stage: {com,seg} registered every cycle into samp (11 bits). This is the only sampling point for asynchronous or bouncing inputs.
- Run counter (8-bit, saturating at 255):
  - If the new sample equals the previous samp, increment.
  - Otherwise load 1.
- Accept event: fires for exactly one cycle, when the run counter transitions to STABLE_CYCLES. A held pattern is accepted once per stable run; re-acceptance requires the pattern to change and return.
- Latency: a pattern applied before edge 0 and held is accepted in the cycle after edge STABLE_CYCLES-1. Its slot is written at edge STABLE_CYCLES.
- On accept, classify by com:
  - 4'b0000: blanking interval; ignored, no error.
  - Exactly one bit set: decode seg with the glyph table.
    - Legal glyph: write the nibble to shadow slot i and set mask[i]. A re-accepted slot is overwritten with the newest value.
    - Illegal glyph: set err and err_cause[0]; slot and mask unchanged.
  - Two or more bits set: set err and err_cause[1]; no slot write.
- Glyph table (seg hex -> value). Any other pattern is illegal.
  - 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7
  - 7F->8, 7B->9, 77->A, 1F->b, 4E->C, 3D->d, 4F->E, 47->F
- Frame completion:
  - On the edge where the mask would become 4'b1111 (including the current write), load digits from the shadow slots (with the new nibble merged), pulse frame_valid for that one cycle, and clear mask to 0000.
  - Shadow slots keep their values.
  - Digit order of arrival is irrelevant.
- err_clr: clears err and err_cause on the next edge. If a new error is detected in the same cycle, the new error wins: the flag is set and only the new cause bit remains.
- frame_valid and err are independent; an error never blocks a frame already in progress.

Test Plan:
- Scan digits 0..3 with seg 79,5B,4E,30 (values 3,5,C,1), each held 6 cycles -> one frame_valid pulse, digits=16'h1C53, err=0; with STABLE_CYCLES=4, first slot written 4 edges after the pattern appears.
- Pattern held 3 cycles, then changed (STABLE_CYCLES=4) -> no accept, mask unchanged; the same pattern held 40 cycles -> exactly one accept.
- com=4'b0100 with seg=7'h00 held 8 cycles -> err=1, err_cause=01, no frame; then err_clr pulse -> err=0, err_cause=00.
- com=4'b0011 held -> err_cause=10. Blanking with com=0000 between digits -> no error, frame still completes.
- Digit 2 accepted twice (values 8 then A) before the rest -> frame shows A in digits[11:8].
- Assert rst after 3 of 4 digits accepted; release and send only the 4th digit -> no frame_valid, digits=0000.
